uart_tx_feeder: RTL and testbench
=================================

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two and at least 2.
REQ-002 Parameter START_TIMEOUT, default 4, tx_clk cycles to wait for tx_busy after a start pulse.
REQ-003 Derived constant AW = log2(DEPTH); it SHALL NOT be overridable.
REQ-004 tx_clk  in  1  transmit bit clock; all logic is clocked on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 push_valid  in  1  producer presents a byte.
REQ-007 push_data  in  8  byte to enqueue.
REQ-008 push_ready  out  1  equals not full; a byte is accepted when push_valid and push_ready are both high.
REQ-009 flush  in  1  discards all queued bytes and clears error flags.
REQ-010 tx_busy  in  1  serializer busy status.
REQ-011 tx_start  out  1  one-cycle start pulse to the serializer.
REQ-012 tx_data  out  8  byte for the serializer; held stable from tx_start until tx_busy falls.
REQ-013 level  out  AW+1  FIFO occupancy, 0..DEPTH.
REQ-014 empty / full  out  1 each  level==0 / level==DEPTH.
REQ-015 overflow  out  1  sticky: a push was attempted while full.
REQ-016 start_err  out  1  sticky: the serializer did not raise tx_busy within START_TIMEOUT.

Function
REQ-017 FIFO SHALL be first-in first-out with wrapping read/write pointers of AW bits; level SHALL change by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
REQ-018 A push while full SHALL be dropped and SHALL set overflow, even if a pop occurs in the same cycle.
REQ-019 FSM states SHALL be F_IDLE, F_START, F_WAIT_BUSY, F_WAIT_DONE.
REQ-020 F_IDLE: if not empty and tx_busy==0, pop the head into the tx_data register and go to F_START; otherwise stay.
REQ-021 F_START: tx_start=1 for exactly this cycle; go to F_WAIT_BUSY and clear the timeout counter.
REQ-022 F_WAIT_BUSY: on tx_busy==1 go to F_WAIT_DONE; otherwise increment the counter, and when it reaches START_TIMEOUT set start_err and go to F_IDLE.
REQ-023 F_WAIT_DONE: on tx_busy==0 go to F_IDLE (byte complete).
REQ-024 tx_start SHALL be 0 in every state except F_START.
REQ-025 Latency, empty FIFO with FSM in F_IDLE: a byte pushed in cycle N SHALL give empty==0 in cycle N+1 and tx_start==1 in cycle N+2.
REQ-026 Back-to-back bytes: the next tx_start SHALL occur no earlier than 2 cycles after tx_busy falls.
REQ-027 flush SHALL zero the pointers and level and clear overflow and start_err on the next edge.
REQ-028 flush SHALL NOT abort the byte already loaded into tx_data; the FSM continues.
REQ-029 flush and push in the same cycle: flush wins and the byte is dropped without setting overflow.
REQ-030 Undefined FSM encoding SHALL return to F_IDLE.

Reset
REQ-031 On rst==0 at a tx_clk edge: FSM=F_IDLE, pointers=0, level=0, tx_start=0, tx_data=8'h00, overflow=0, start_err=0, counter=0.
REQ-032 After reset: empty=1, full=0, push_ready=1.
REQ-033 FIFO storage contents need no reset.
REQ-034 Reset mid-transfer SHALL drop the in-flight byte and all queued bytes with no spurious tx_start.

Structure
REQ-035 The feeder FSM enum and the START_TIMEOUT default SHALL live in shared package uart_pkg.
REQ-036 FIFO storage and pointers SHALL be sub-module uart_byte_fifo (push/pop/level/full/empty); the FSM stays in uart_tx_feeder.

Verification
REQ-037 After reset, push 8'hA5 with a model serializer (busy 1 cycle after start, for 11 cycles) -> tx_start in cycle N+2, tx_data==8'hA5 until busy falls, level returns to 0.
REQ-038 Push 16 bytes 0x00..0x0F with tx_busy held 1, then a 17th byte 0xFF -> full==1, push_ready==0, overflow==1; release busy -> bytes 0x00..0x0F transmitted in order and 0xFF never sent.
REQ-039 Hold tx_busy==0 permanently and push 8'h3C -> start_err==1 exactly START_TIMEOUT cycles after F_WAIT_BUSY is entered, FSM back in F_IDLE, a retry start for the next byte.
REQ-040 With 5 bytes queued and byte 0x11 in flight, assert flush for one cycle -> 0x11 completes, level==0, no further tx_start, overflow and start_err cleared.
REQ-041 At level==DEPTH-1, push and pop in the same cycle repeatedly across a pointer wrap -> level constant, order preserved.
REQ-042 Assert rst==0 while in F_WAIT_DONE with 3 bytes queued -> next cycle all outputs at reset values, tx_start stays 0 until a new push.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART transmit feeder
package uart_pkg;

  localparam int START_TIMEOUT_DEF = 4;

  typedef enum logic [1:0] {
    F_IDLE      = 2'd0,
    F_START     = 2'd1,
    F_WAIT_BUSY = 2'd2,
    F_WAIT_DONE = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - byte FIFO with wrapping pointers, occupancy and flush
module uart_byte_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          tx_clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [7:0]    head,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] LEVEL_MAX = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_en;
  logic          pop_en;

  // a push into a full queue is dropped; popping an empty queue is ignored
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  assign full  = (level == LEVEL_MAX);
  assign empty = (level == '0);
  assign head  = mem[rd_ptr];

  // storage write; contents are never reset, only pointers matter
  always_ff @(posedge tx_clk) begin
    if (push_en && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // pointers and occupancy; flush behaves like a reset of the bookkeeping
  always_ff @(posedge tx_clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_en, pop_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - queues bytes and hands them one at a time to a UART serializer
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          tx_clk,
  input  logic          rst,
  input  logic          push_valid,
  input  logic [7:0]    push_data,
  output logic          push_ready,
  input  logic          flush,
  input  logic          tx_busy,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          start_err
);

  localparam int CW = $clog2(START_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(START_TIMEOUT);

  feeder_state_t state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [7:0]    head;
  logic          pop;
  logic          push;

  assign push       = push_valid && !flush;
  assign pop        = (state == F_IDLE) && !empty && !tx_busy;
  assign push_ready = !full;
  assign cnt_inc    = cnt + CW'(1);

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .tx_clk    (tx_clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // sticky overflow: any push attempt against a full queue, unless flushed
  always_ff @(posedge tx_clk) begin
    if (!rst || flush) begin
      overflow <= 1'b0;
    end else if (push_valid && full) begin
      overflow <= 1'b1;
    end
  end

  // handshake FSM: load head, pulse start, wait for busy to rise then fall
  always_ff @(posedge tx_clk) begin
    if (!rst) begin
      state     <= F_IDLE;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      cnt       <= '0;
      start_err <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        F_IDLE: begin
          if (!empty && !tx_busy) begin
            tx_data  <= head;
            tx_start <= 1'b1;
            state    <= F_START;
          end
        end
        F_START: begin
          cnt   <= '0;
          state <= F_WAIT_BUSY;
        end
        F_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= F_WAIT_DONE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == TO_LIM) begin
              start_err <= 1'b1;
              state     <= F_IDLE;
            end
          end
        end
        F_WAIT_DONE: begin
          if (!tx_busy) begin
            state <= F_IDLE;
          end
        end
        default: state <= F_IDLE;
      endcase
      // flush clears the error flag but never disturbs the byte in flight
      if (flush) begin
        start_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed self-checking bench for uart_tx_feeder
module tb_uart_tx_feeder;

  logic       tx_clk = 1'b0;
  logic       rst = 1'b0;
  logic       push_valid = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       push_ready;
  logic       flush = 1'b0;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       start_err;

  logic       man_busy = 1'b0;
  logic       ser_mode = 1'b0;
  int         acnt = 0;
  int         cyc = 0;
  logic [7:0] sent[$];
  int         start_cyc[$];
  logic [7:0] exp_q[$];
  int         total = 0;
  int         bad = 0;

  uart_tx_feeder dut (
    .tx_clk     (tx_clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .flush      (flush),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .level      (level),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .start_err  (start_err)
  );

  always #5 tx_clk = ~tx_clk;

  assign tx_busy = ser_mode ? (acnt != 0) : man_busy;

  // model serializer: busy from the cycle after start, for 11 cycles
  always @(posedge tx_clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      acnt <= 0;
    end else if (tx_start) begin
      acnt <= 11;
    end else if (acnt != 0) begin
      acnt <= acnt - 1;
    end
  end

  // record every start pulse with the byte presented
  always @(posedge tx_clk) begin
    if (tx_start) begin
      sent.push_back(tx_data);
      start_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge tx_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sent(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (sent.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(sent.size() >= n), 32'd1);
  endtask

  initial begin
    logic hold;
    int   n_sent;
    int   d;

    // reset state
    rst = 1'b0;
    tick();
    tick();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_push_ready", 32'(push_ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_start_err", 32'(start_err), 32'd0);
    rst = 1'b1;
    tick();

    // single byte with model serializer, latency N+1 / N+2
    ser_mode = 1'b1;
    push_valid = 1'b1;
    push_data = 8'hA5;
    tick();
    push_valid = 1'b0;
    chk("lat_empty_n1", 32'(empty), 32'd0);
    chk("lat_level_n1", 32'(level), 32'd1);
    chk("lat_start_n1", 32'(tx_start), 32'd0);
    tick();
    chk("lat_start_n2", 32'(tx_start), 32'd1);
    chk("lat_data_n2", 32'(tx_data), 32'hA5);
    hold = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (tx_data !== 8'hA5) hold = 1'b0;
    end
    chk("a5_hold", 32'(hold), 32'd1);
    tick();
    tick();
    tick();
    chk("a5_level0", 32'(level), 32'd0);
    chk("a5_sent_cnt", 32'(sent.size()), 32'd1);

    // fill to full with busy held, then overflow attempt
    ser_mode = 1'b0;
    man_busy = 1'b1;
    sent.delete();
    start_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      push_valid = 1'b1;
      push_data = 8'(i);
      tick();
    end
    push_valid = 1'b0;
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_push_ready", 32'(push_ready), 32'd0);
    chk("fill_no_ovf", 32'(overflow), 32'd0);
    push_valid = 1'b1;
    push_data = 8'hFF;
    tick();
    push_valid = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    ser_mode = 1'b1;
    wait_sent(16, 400, "drain_timeout");
    for (int i = 0; i < 30; i++) tick();
    chk("drain_cnt", 32'(sent.size()), 32'd16);
    for (int i = 0; i < 16 && i < sent.size(); i++) begin
      chk($sformatf("drain_byte%0d", i), 32'(sent[i]), 32'(i));
    end
    d = (start_cyc.size() >= 2) ? (start_cyc[1] - start_cyc[0]) : 0;
    chk("b2b_gap", 32'(d), 32'd14);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // start timeout with busy stuck low, then retry of the next byte
    ser_mode = 1'b0;
    man_busy = 1'b0;
    push_valid = 1'b1;
    push_data = 8'h3C;
    tick();
    push_data = 8'h3D;
    tick();
    push_valid = 1'b0;
    chk("to_start", 32'(tx_start), 32'd1);
    chk("to_data", 32'(tx_data), 32'h3C);
    tick();
    tick();
    tick();
    tick();
    chk("to_err_early", 32'(start_err), 32'd0);
    tick();
    chk("to_err_set", 32'(start_err), 32'd1);
    tick();
    chk("to_retry_start", 32'(tx_start), 32'd1);
    chk("to_retry_data", 32'(tx_data), 32'h3D);
    for (int i = 0; i < 8; i++) tick();
    chk("to_err_sticky", 32'(start_err), 32'd1);

    // flush with 5 queued and 0x11 in flight
    push_valid = 1'b1;
    push_data = 8'h11;
    tick();
    push_data = 8'h21;
    tick();
    chk("fl_start", 32'(tx_start), 32'd1);
    chk("fl_data", 32'(tx_data), 32'h11);
    push_data = 8'h22;
    tick();
    push_data = 8'h23;
    man_busy = 1'b1;
    tick();
    push_data = 8'h24;
    tick();
    push_data = 8'h25;
    tick();
    push_valid = 1'b0;
    chk("fl_level5", 32'(level), 32'd5);
    flush = 1'b1;
    push_valid = 1'b1;
    push_data = 8'h99;
    tick();
    flush = 1'b0;
    push_valid = 1'b0;
    chk("fl_level0", 32'(level), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    chk("fl_ovf_clr", 32'(overflow), 32'd0);
    chk("fl_err_clr", 32'(start_err), 32'd0);
    chk("fl_inflight", 32'(tx_data), 32'h11);
    n_sent = sent.size();
    tick();
    tick();
    tick();
    man_busy = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("fl_no_start", 32'(sent.size()), 32'(n_sent));
    chk("fl_data_kept", 32'(tx_data), 32'h11);

    // simultaneous push/pop at DEPTH-1 across a pointer wrap
    man_busy = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 15; i++) begin
      push_valid = 1'b1;
      push_data = 8'(8'h40 + i);
      exp_q.push_back(8'(8'h40 + i));
      tick();
    end
    push_valid = 1'b0;
    chk("wrap_level_init", 32'(level), 32'd15);
    for (int k = 0; k < 20; k++) begin
      logic [7:0] e;
      man_busy = 1'b0;
      push_valid = 1'b1;
      push_data = 8'(8'h60 + k);
      exp_q.push_back(8'(8'h60 + k));
      tick();
      push_valid = 1'b0;
      man_busy = 1'b1;
      e = exp_q.pop_front();
      chk($sformatf("wrap_start%0d", k), 32'(tx_start), 32'd1);
      chk($sformatf("wrap_data%0d", k), 32'(tx_data), 32'(e));
      chk($sformatf("wrap_level%0d", k), 32'(level), 32'd15);
      tick();
      tick();
      man_busy = 1'b0;
      tick();
    end
    man_busy = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("wrap_flush_level", 32'(level), 32'd0);

    // reset while in F_WAIT_DONE with 3 queued
    man_busy = 1'b0;
    push_valid = 1'b1;
    push_data = 8'hB1;
    tick();
    push_data = 8'hB2;
    tick();
    chk("mr_start", 32'(tx_start), 32'd1);
    push_data = 8'hB3;
    tick();
    push_data = 8'hB4;
    man_busy = 1'b1;
    tick();
    push_valid = 1'b0;
    chk("mr_level3", 32'(level), 32'd3);
    rst = 1'b0;
    tick();
    chk("mr_tx_start", 32'(tx_start), 32'd0);
    chk("mr_tx_data", 32'(tx_data), 32'h00);
    chk("mr_level", 32'(level), 32'd0);
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_full", 32'(full), 32'd0);
    chk("mr_push_ready", 32'(push_ready), 32'd1);
    chk("mr_overflow", 32'(overflow), 32'd0);
    chk("mr_start_err", 32'(start_err), 32'd0);
    rst = 1'b1;
    man_busy = 1'b0;
    n_sent = sent.size();
    for (int i = 0; i < 10; i++) tick();
    chk("mr_no_start", 32'(sent.size()), 32'(n_sent));
    push_valid = 1'b1;
    push_data = 8'h77;
    tick();
    push_valid = 1'b0;
    tick();
    chk("mr_new_start", 32'(tx_start), 32'd1);
    chk("mr_new_data", 32'(tx_data), 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
